// File: rtl/mp_add_pkg.sv
// Shared definitions for the sequential multi-precision adder: state encoding
// and the slice-index width helper.
package mp_add_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = IDLE,
        S_RUN  = RUN,
        S_DONE = DONE
    } state_t;

    // Index width for K slices; never narrower than one bit so K=1 still has a register.
    function automatic int clog2(input int k);
        int r;
        r = 0;
        while ((1 << r) < k) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/mp_add_seq_if.sv
// Request/result bundle for mp_add_seq. The ovf signal exists only when
// MP_ADD_OVF_EN is defined.
interface mp_add_seq_if #(
    parameter int N = 16,
    parameter int K = 4
);
    localparam int W = N * K;

    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
`ifdef MP_ADD_OVF_EN
    logic         ovf;

    modport master (output start, a, b, input busy, done, sum, cout, ovf);
    modport slave  (input start, a, b, output busy, done, sum, cout, ovf);
`else
    modport master (output start, a, b, input busy, done, sum, cout);
    modport slave  (input start, a, b, output busy, done, sum, cout);
`endif

endinterface

// File: rtl/mp_add_seq_add_slice.sv
// Combinational N-bit adder with carry-in; also reports the carry into the
// top bit so the caller can derive signed overflow.
module add_slice #(
    parameter int N = 16
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    input  logic         cin_i,
    output logic [N-1:0] s_o,
    output logic         cout_o,
    output logic         c_msb_o
);
    logic [N:0] full;

    assign full    = {1'b0, a_i} + {1'b0, b_i} + {{N{1'b0}}, cin_i};
    assign s_o     = full[N-1:0];
    assign cout_o  = full[N];
    // Sum bit = a ^ b ^ carry-in, so the carry into the MSB falls out of the sum.
    assign c_msb_o = a_i[N-1] ^ b_i[N-1] ^ full[N-1];

endmodule

// File: rtl/mp_add_seq.sv
// Sequential W-bit adder: one N-bit slice per cycle, LSB slice first, with a
// one-cycle done pulse. Defining MP_ADD_OVF_EN adds a signed-overflow output.
module mp_add_seq
    import mp_add_pkg::*;
#(
    parameter int N = 16,
    parameter int K = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    mp_add_seq_if.slave   bus
);
    localparam int W  = N * K;
    localparam int IW = clog2(K);

    state_t        state_q;
    logic [IW-1:0] idx_q;
    logic          carry_q;
    logic [W-1:0]  a_q;
    logic [W-1:0]  b_q;
    logic [W-1:0]  sum_q;
    logic          cout_q;
    logic          busy_q;
    logic          done_q;
    logic          ovf_q;

    logic [N-1:0]  a_sl;
    logic [N-1:0]  b_sl;
    logic [N-1:0]  s_sl;
    logic          c_sl;
    logic          c_msb;
    logic          last;

    always_comb begin
        a_sl = '0;
        b_sl = '0;
        for (int k = 0; k < K; k++) begin
            if (idx_q == IW'(k)) begin
                a_sl = a_q[k*N +: N];
                b_sl = b_q[k*N +: N];
            end
        end
    end

    assign last = (idx_q == IW'(K - 1));

    add_slice #(.N(N)) u_add (
        .a_i     (a_sl),
        .b_i     (b_sl),
        .cin_i   (carry_q),
        .s_o     (s_sl),
        .cout_o  (c_sl),
        .c_msb_o (c_msb)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                // DONE accepts a new start exactly like IDLE for back-to-back ops.
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        a_q     <= bus.a;
                        b_q     <= bus.b;
                        carry_q <= 1'b0;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_RUN;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_RUN: begin
                    for (int k = 0; k < K; k++) begin
                        if (idx_q == IW'(k)) sum_q[k*N +: N] <= s_sl;
                    end
                    carry_q <= c_sl;
                    if (last) begin
                        idx_q   <= '0;
                        cout_q  <= c_sl;
                        ovf_q   <= c_msb ^ c_sl;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;

`ifdef MP_ADD_OVF_EN
    assign bus.ovf = ovf_q;
`else
    logic ovf_unused;
    assign ovf_unused = ovf_q;
`endif

endmodule

// File: tb/tb_mp_add_seq.sv
// Directed-vector bench for mp_add_seq with N=16, K=4; ovf checks are compiled
// in when MP_ADD_OVF_EN is defined.
module tb_mp_add_seq;
    logic clk;
    logic rst_n;
    int   tests_run;
    int   tests_failed;

    mp_add_seq_if #(.N(16), .K(4)) bus ();

    mp_add_seq #(.N(16), .K(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulses start for one cycle and waits (bounded) for done; returns the
    // number of edges from the accepting edge to the done cycle, and the result.
    task automatic do_op(input logic [63:0] av, input logic [63:0] bv,
                         output int lat, output logic [63:0] s,
                         output logic c, output logic ov);
        int cnt;
        bus.a     = av;
        bus.b     = bv;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        cnt = 1;
        while (bus.done !== 1'b1 && cnt < 20) begin
            tick();
            cnt++;
        end
        lat = cnt;
        s   = bus.sum;
        c   = bus.cout;
`ifdef MP_ADD_OVF_EN
        ov  = bus.ovf;
`else
        ov  = 1'b0;
`endif
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.a = 64'h0;
        bus.b = 64'h0;
        tick();
        tick();
        tests_run++;
        if (bus.busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        tests_run++;
        if (bus.done !== 1'b0) begin tests_failed++; $display("FAIL reset_done got %b want 0", bus.done); end
        tests_run++;
        if (bus.sum !== 64'h0) begin tests_failed++; $display("FAIL reset_sum got %h want 0", bus.sum); end
        tests_run++;
        if (bus.cout !== 1'b0) begin tests_failed++; $display("FAIL reset_cout got %b want 0", bus.cout); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        int lat; logic [63:0] s; logic c, ov;
        do_op(64'h0000_0000_0000_FFFF, 64'h1, lat, s, c, ov);
        tests_run++;
        if (lat !== 5) begin tests_failed++; $display("FAIL basic_latency got %0d want 5", lat); end
        tests_run++;
        if (s !== 64'h0000_0000_0001_0000) begin tests_failed++; $display("FAIL basic_sum got %h want 0000000000010000", s); end
        tests_run++;
        if (c !== 1'b0) begin tests_failed++; $display("FAIL basic_cout got %b want 0", c); end
        tick();
        tests_run++;
        if (bus.done !== 1'b0) begin tests_failed++; $display("FAIL basic_done_pulse got %b want 0", bus.done); end
    endtask

    task automatic test_ripple();
        int lat; logic [63:0] s; logic c, ov;
        do_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, lat, s, c, ov);
        tests_run++;
        if (s !== 64'h0) begin tests_failed++; $display("FAIL ripple_sum got %h want 0", s); end
        tests_run++;
        if (c !== 1'b1) begin tests_failed++; $display("FAIL ripple_cout got %b want 1", c); end
`ifdef MP_ADD_OVF_EN
        tests_run++;
        if (ov !== 1'b0) begin tests_failed++; $display("FAIL ripple_ovf got %b want 0", ov); end
`endif
        tick();
    endtask

    task automatic test_patterns();
        int lat; logic [63:0] s; logic c, ov;
        do_op(64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, lat, s, c, ov);
        tests_run++;
        if (s !== 64'hFFFF_FFFF_FFFF_FFFF) begin tests_failed++; $display("FAIL alt_sum got %h want ffffffffffffffff", s); end
        tests_run++;
        if (c !== 1'b0) begin tests_failed++; $display("FAIL alt_cout got %b want 0", c); end
        tick();
        do_op(64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, lat, s, c, ov);
        tests_run++;
        if (s !== 64'hFFFF_FFFF_FFFF_FFFE) begin tests_failed++; $display("FAIL maxpos_sum got %h want fffffffffffffffe", s); end
        tests_run++;
        if (c !== 1'b0) begin tests_failed++; $display("FAIL maxpos_cout got %b want 0", c); end
`ifdef MP_ADD_OVF_EN
        tests_run++;
        if (ov !== 1'b1) begin tests_failed++; $display("FAIL maxpos_ovf got %b want 1", ov); end
`endif
        tick();
    endtask

    task automatic test_start_while_busy();
        int done_cnt;
        bus.a = 64'h1;
        bus.b = 64'h2;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        done_cnt = 0;
        for (int cyc = 1; cyc <= 10; cyc++) begin
            if (cyc == 3) begin
                bus.a = 64'hFFFF_FFFF_FFFF_FFFF;
                bus.b = 64'hFFFF_FFFF_FFFF_FFFF;
                bus.start = 1'b1;
            end
            if (cyc > 1) tick();
            if (cyc == 3) begin
                bus.start = 1'b0;
            end
            tests_run++;
            if (bus.busy !== (cyc <= 4)) begin
                tests_failed++;
                $display("FAIL busy_profile cycle %0d got %b want %b", cyc, bus.busy, (cyc <= 4));
            end
            if (bus.done === 1'b1) begin
                done_cnt++;
                tests_run++;
                if (cyc !== 5) begin tests_failed++; $display("FAIL busy_done_cycle got %0d want 5", cyc); end
                tests_run++;
                if (bus.sum !== 64'h3) begin tests_failed++; $display("FAIL busy_sum got %h want 3", bus.sum); end
                tests_run++;
                if (bus.cout !== 1'b0) begin tests_failed++; $display("FAIL busy_cout got %b want 0", bus.cout); end
            end
        end
        tests_run++;
        if (done_cnt !== 1) begin tests_failed++; $display("FAIL busy_done_count got %0d want 1", done_cnt); end
    endtask

    task automatic test_reset_mid_run();
        int lat; int done_cnt; logic [63:0] s; logic c, ov;
        bus.a = 64'h1;
        bus.b = 64'h2;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tests_run++;
        if (bus.busy !== 1'b0) begin tests_failed++; $display("FAIL abort_busy got %b want 0", bus.busy); end
        tests_run++;
        if (bus.done !== 1'b0) begin tests_failed++; $display("FAIL abort_done got %b want 0", bus.done); end
        tests_run++;
        if (bus.sum !== 64'h0) begin tests_failed++; $display("FAIL abort_sum got %h want 0", bus.sum); end
        tests_run++;
        if (bus.cout !== 1'b0) begin tests_failed++; $display("FAIL abort_cout got %b want 0", bus.cout); end
        done_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (bus.done === 1'b1 || bus.busy === 1'b1) done_cnt++;
        end
        tests_run++;
        if (done_cnt !== 0) begin tests_failed++; $display("FAIL abort_activity got %0d want 0", done_cnt); end
        do_op(64'h5, 64'h7, lat, s, c, ov);
        tests_run++;
        if (lat !== 5) begin tests_failed++; $display("FAIL abort_fresh_latency got %0d want 5", lat); end
        tests_run++;
        if (s !== 64'hC) begin tests_failed++; $display("FAIL abort_fresh_sum got %h want c", s); end
        tick();
    endtask

    task automatic test_back_to_back();
        int done_cnt;
        bus.a = 64'h10;
        bus.b = 64'h20;
        bus.start = 1'b1;
        done_cnt = 0;
        for (int cyc = 1; cyc <= 15; cyc++) begin
            tick();
            if (cyc == 15) bus.start = 1'b0;
            tests_run++;
            if (bus.done !== (cyc % 5 == 0)) begin
                tests_failed++;
                $display("FAIL b2b_done cycle %0d got %b want %b", cyc, bus.done, (cyc % 5 == 0));
            end
            tests_run++;
            if (bus.busy !== (cyc % 5 != 0)) begin
                tests_failed++;
                $display("FAIL b2b_busy cycle %0d got %b want %b", cyc, bus.busy, (cyc % 5 != 0));
            end
            if (bus.done === 1'b1) begin
                done_cnt++;
                tests_run++;
                if (bus.sum !== 64'h30 || bus.cout !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL b2b_result got %h/%b want 30/0", bus.sum, bus.cout);
                end
            end
        end
        tests_run++;
        if (done_cnt !== 3) begin tests_failed++; $display("FAIL b2b_count got %0d want 3", done_cnt); end
        tick();
        tests_run++;
        if (bus.busy !== 1'b0) begin tests_failed++; $display("FAIL b2b_drain_busy got %b want 0", bus.busy); end
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.a = 64'h0;
        bus.b = 64'h0;
        #1;
        test_reset();
        test_basic();
        test_ripple();
        test_patterns();
        test_start_while_busy();
        test_reset_mid_run();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
